// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device and reports the device ACK or a
// failure. Both PS/2 lines are open-drain and are driven through output
// enables. A top-level tristate turns each enable into "pin = 0" when the
// enable is high and "pin = Z" when it is low.
//
// Frame on the wire: start(0), d0..d7 (LSB first), odd parity, stop(1). The
// device then pulls data low for one more clock as the ACK.
//
// Parameters:
//   INHIBIT_CYCLES  cycles the clock line is held low before the request
//   TIMEOUT_CYCLES  cycles allowed from releasing the clock to a completed ACK
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   cmd_valid   request to send cmd_data
//   cmd_data    command byte
//   cmd_ready   high when a command can be accepted
//   done        one-cycle pulse: byte sent and ACK received
//   error       one-cycle pulse: no ACK, or timeout
//   rx_inhibit  high whenever a transfer is in progress (receiver ignores clk)
//   ps2_clk_in  raw PS2_CLK pin
//   ps2_dat_in  raw PS2_DAT pin
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One timer serves both the inhibit phase and the transfer timeout; the
    // two never overlap, so it is sized for the larger of the two limits.
    localparam int unsigned MaxCycles =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(MaxCycles + 1);

    localparam logic [TW-1:0] InhibitLast = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StStart,
        StData,
        StParity,
        StAck,
        StWaitRel
    } state_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_cnt_q;   // index of the data bit currently on the line
    logic [7:0]    shift_q;
    logic          parity_q;

    // Two-flop synchronisers plus one history flop for edge detection.
    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic dat_meta_q;
    logic dat_sync_q;

    logic fall;
    logic timed_state;
    logic timeout_hit;

    always_comb begin
        fall        = clk_prev_q & ~clk_sync_q;
        timed_state = (state_q == StStart)  || (state_q == StData) ||
                      (state_q == StParity) || (state_q == StAck)  ||
                      (state_q == StWaitRel);
        // The timer counts cycles spent since START was entered, so matching
        // TimeoutLast here raises error exactly TIMEOUT_CYCLES after entry.
        timeout_hit = timed_state && (timer_q == TimeoutLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            // Idle lines are high; presetting the synchronisers to 1 keeps a
            // released bus from looking like an edge straight after reset.
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            rx_inhibit <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;

            done  <= 1'b0;
            error <= 1'b0;

            if (timeout_hit) begin
                // Timeout wins over any clock edge arriving in the same cycle.
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                error      <= 1'b1;
                rx_inhibit <= 1'b0;
                state_q    <= StIdle;
            end else begin
                if (timed_state) begin
                    timer_q <= timer_q + 1'b1;
                end

                unique case (state_q)
                    StIdle: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        rx_inhibit <= 1'b0;
                        if (cmd_valid && cmd_ready) begin
                            shift_q    <= cmd_data;
                            parity_q   <= ~^cmd_data;
                            timer_q    <= '0;
                            bit_cnt_q  <= '0;
                            cmd_ready  <= 1'b0;
                            ps2_clk_oe <= 1'b1;
                            rx_inhibit <= 1'b1;
                            state_q    <= StInhibit;
                        end else begin
                            // Also re-arms ready one cycle after done/error.
                            cmd_ready <= 1'b1;
                        end
                    end

                    StInhibit: begin
                        if (timer_q == InhibitLast) begin
                            ps2_dat_oe <= 1'b1;
                            state_q    <= StReq;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end

                    StReq: begin
                        // Release the clock with data held low: that is the
                        // request-to-send and the start bit at once.
                        ps2_clk_oe <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StStart;
                    end

                    StStart: begin
                        if (fall) begin
                            ps2_dat_oe <= ~shift_q[0];
                            shift_q    <= shift_q >> 1;
                            bit_cnt_q  <= '0;
                            state_q    <= StData;
                        end
                    end

                    StData: begin
                        if (fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                ps2_dat_oe <= ~parity_q;
                                state_q    <= StParity;
                            end else begin
                                ps2_dat_oe <= ~shift_q[0];
                                shift_q    <= shift_q >> 1;
                                bit_cnt_q  <= bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    StParity: begin
                        if (fall) begin
                            ps2_dat_oe <= 1'b0;   // stop bit is a released line
                            state_q    <= StAck;
                        end
                    end

                    StAck: begin
                        if (fall) begin
                            if (!dat_sync_q) begin
                                state_q <= StWaitRel;
                            end else begin
                                error      <= 1'b1;
                                rx_inhibit <= 1'b0;
                                state_q    <= StIdle;
                            end
                        end
                    end

                    StWaitRel: begin
                        if (clk_sync_q && dat_sync_q) begin
                            done       <= 1'b1;
                            rx_inhibit <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int unsigned InhCyc = 20;
    localparam int unsigned ToCyc  = 500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       done;
    logic       error;
    logic       rx_inhibit;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    // Device side of the open-drain bus: 1 = released.
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk_line;
    logic ps2_dat_line;
    assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

    int checks = 0;
    int failures = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhCyc),
        .TIMEOUT_CYCLES(ToCyc)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .done      (done),
        .error     (error),
        .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    int   done_rise = 0, err_rise = 0, done_hi = 0, err_hi = 0, accepts = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    logic pulse_ready = 1'b0, post_ready = 1'b0, post_pulse = 1'b0;
    logic [1:0] pulse_oe = 2'b00, post_oe = 2'b00;

    always @(negedge clk) begin
        done_prev <= done;
        err_prev  <= error;
        if (done && !done_prev) done_rise <= done_rise + 1;
        if (error && !err_prev) err_rise <= err_rise + 1;
        if (done) done_hi <= done_hi + 1;
        if (error) err_hi <= err_hi + 1;
        if (done || error) begin
            pulse_ready <= cmd_ready;
            pulse_oe    <= {ps2_clk_oe, ps2_dat_oe};
        end
        if (done_prev || err_prev) begin
            post_ready <= cmd_ready;
            post_oe    <= {ps2_clk_oe, ps2_dat_oe};
            post_pulse <= done | error;
        end
        if (cmd_valid && cmd_ready) accepts <= accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame as the device sees it at its rising edges:
    // bits[7:0] = data LSB first, bits[8] = odd parity, bits[9] = stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic issue(input logic [7:0] b, input string tag);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_ready_seen"}, 32'(n < 200), 1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick(1);
        cmd_valid = 1'b0;
        check({tag, "_accept"}, {cmd_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 4'b0110);
    endtask

    // Device BFM: 40-cycle clock, samples data at each rising edge.
    // abort_at >= 0 stops after that many+1 falls with the clock still low.
    task automatic device_xfer(input bit ack_ok, input int abort_at, input string tag,
                               output logic [9:0] bits);
        int n = 0;
        bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 2000) begin
            tick(1);
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 2000), 1);
        tick(5);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            if (i == abort_at) begin
                tick(10);
                return;
            end
            tick(20);
            dev_clk = 1'b1;
            bits[i] = ps2_dat_line;
            tick(20);
        end
        dev_dat = ack_ok ? 1'b0 : 1'b1;
        tick(5);
        dev_clk = 1'b0;
        tick(20);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic wait_outcome(input int base, input string tag);
        int n = 0;
        while ((done_rise + err_rise) == base && n < 600) begin
            tick(1);
            n++;
        end
        check({tag, "_outcome_seen"}, 32'(n < 600), 1);
        tick(2);
    endtask

    task automatic transact(input logic [7:0] b, input bit ack_ok, input string tag);
        logic [9:0] bits;
        int base, dr0, er0, dh0, eh0;
        issue(b, tag);
        dr0 = done_rise; er0 = err_rise; dh0 = done_hi; eh0 = err_hi;
        base = dr0 + er0;
        device_xfer(ack_ok, -1, tag, bits);
        check({tag, "_frame"}, 32'(bits), 32'(exp_frame(b)));
        wait_outcome(base, tag);
        check({tag, "_done_cnt"}, done_rise - dr0, ack_ok ? 1 : 0);
        check({tag, "_err_cnt"}, err_rise - er0, ack_ok ? 0 : 1);
        check({tag, "_pulse_width"}, (done_hi - dh0) + (err_hi - eh0), 1);
        check({tag, "_ready_in_pulse"}, 32'(pulse_ready), 0);
        check({tag, "_post"}, {post_pulse, post_ready, post_oe}, 4'b0100);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        bit         ack;
        int         n, t0, acc0, dr0, er0, base;

        // Reset state.
        tick(3);
        check("reset_state", {cmd_ready, done, error, rx_inhibit, ps2_clk_oe, ps2_dat_oe},
              6'b100000);
        reset = 1'b0;
        tick(2);

        // 0xED with inhibit/request timing checked.
        issue(8'hED, "ed");
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 1000) begin
            n++;
            tick(1);
        end
        check("ed_inhibit_len", n, InhCyc);
        check("ed_req", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
        tick(1);
        check("ed_start", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        dr0 = done_rise; er0 = err_rise; base = dr0 + er0;
        device_xfer(1'b1, -1, "ed", bits);
        check("ed_frame", 32'(bits), 32'(10'b11_1110_1101));
        wait_outcome(base, "ed");
        check("ed_done", done_rise - dr0, 1);
        check("ed_no_err", err_rise - er0, 0);
        check("ed_post", {post_pulse, post_ready, post_oe}, 4'b0100);

        // 0xF4: parity 0, normal ACK.
        transact(8'hF4, 1'b1, "f4");

        // 0xFF with no ACK.
        transact(8'hFF, 1'b0, "ff_nack");

        // Device never clocks: timeout.
        issue(8'hA5, "tmo");
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 100) begin
            tick(1);
            n++;
        end
        check("tmo_start_seen", 32'(n < 100), 1);
        t0 = cyc;
        dr0 = done_rise;
        n = 0;
        while (!error && n < 1000) begin
            tick(1);
            n++;
        end
        check("tmo_latency", cyc - t0, ToCyc);
        check("tmo_oe_at_err", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        tick(1);
        check("tmo_post", {error, cmd_ready, ps2_clk_oe, ps2_dat_oe}, 4'b0100);
        check("tmo_no_done", done_rise - dr0, 0);

        // cmd_valid held with 0x00 during a 0xED transfer.
        issue(8'hED, "hold");
        cmd_valid = 1'b1;
        cmd_data  = 8'h00;
        acc0 = accepts;
        dr0 = done_rise; base = done_rise + err_rise;
        device_xfer(1'b1, -1, "hold", bits);
        check("hold_frame_ed", 32'(bits), 32'(exp_frame(8'hED)));
        wait_outcome(base, "hold");
        check("hold_done", done_rise - dr0, 1);
        cmd_valid = 1'b0;
        check("hold_accepts", accepts - acc0, 1);
        check("hold_second_busy", {cmd_ready, rx_inhibit, ps2_clk_oe}, 3'b011);
        dr0 = done_rise; base = done_rise + err_rise;
        device_xfer(1'b1, -1, "zero", bits);
        check("zero_frame", 32'(bits), 32'(exp_frame(8'h00)));
        check("zero_parity", 32'(bits[8]), 1);
        wait_outcome(base, "zero");
        check("zero_done", done_rise - dr0, 1);

        // Reset during data bit 4 of 0xED.
        issue(8'hED, "rst");
        device_xfer(1'b1, 4, "rst", bits);
        check("rst_bit4_drive", {rx_inhibit, ps2_dat_oe}, 2'b11);
        dr0 = done_rise; er0 = err_rise;
        reset = 1'b1;
        tick(1);
        check("rst_state", {cmd_ready, done, error, rx_inhibit, ps2_clk_oe, ps2_dat_oe},
              6'b100000);
        reset = 1'b0;
        dev_clk = 1'b1;
        tick(30);
        check("rst_no_pulse", (done_rise - dr0) + (err_rise - er0), 0);
        transact(8'hF4, 1'b1, "rst_f4");

        // Randomised commands and ACK outcomes.
        for (int k = 0; k < 4; k++) begin
            b   = 8'($urandom_range(0, 255));
            ack = 1'($urandom_range(0, 1));
            transact(b, ack, $sformatf("rnd%0d", k));
        end

        check("never_both", 32'(done & error), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send direction of the keyboard link, complementing the existing keyboard receive path.
- Sends a one-byte command to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) and reports the device ACK or a failure.
- Drives PS2_CLK/PS2_DAT open-drain through two output-enable lines; a top-level tristate makes each line 0 when its enable is high and Z otherwise.
- Asserts rx_inhibit while sending, so the receiver ignores clock edges that the transmitter itself causes.

Parameters:
- INHIBIT_CYCLES, 6000, cycles the host holds the clock line low before the start bit (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum cycles from releasing the clock to a completed ACK (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  request to send cmd_data.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  high when a command can be accepted.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: no ACK, or timeout.
- rx_inhibit  out  1  high whenever the block is not in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin.
- ps2_dat_in  in  1  raw PS2_DAT pin.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

Behaviour:
- Clock is synchronous, reset is synchronous active-high.
- All outputs are registered.

Input synchronisation:
- ps2_clk_in and ps2_dat_in each pass through a 2-FF synchroniser.
- fall = synced clock was 1 in the previous cycle and is 0 now.
- Line changes are therefore visible 3 clk cycles after the pin edge.

Reset:
- At the next clk edge the state becomes IDLE.
- cmd_ready=1, done=0, error=0, rx_inhibit=0, both oe=0 (lines released).
- The bit counter, shift register and timers clear.
- Reset during a transfer abandons it with no done and no error pulse.

Accept:
- A command is accepted when cmd_valid && cmd_ready.
- cmd_data is latched and parity is computed as p = ~^cmd_data (odd parity).
- The next cycle is in INHIBIT and cmd_ready=0.
- cmd_valid while not ready is ignored; nothing is queued.

State machine:
- IDLE:
  - cmd_ready=1, both oe=0.
  - Go to INHIBIT on accept.
- INHIBIT:
  - clk_oe=1.
  - Count INHIBIT_CYCLES cycles, then go to REQ.
- REQ:
  - One cycle with clk_oe=1 and dat_oe=1.
  - Go to START.
- START:
  - clk_oe=0 (clock released), dat_oe=1 (start bit 0).
  - The timeout counter starts here.
  - On fall, drive bit0 and go to DATA.
- DATA:
  - On each fall, advance to the next bit; dat_oe = ~bit (LSB first).
  - After bit7 has been driven, the next fall drives parity p and goes to PARITY.
- PARITY:
  - On fall, dat_oe=0 (stop bit 1) and go to ACK.
- ACK:
  - On fall, sample synced data.
  - 0 → go to WAIT_REL.
  - 1 → pulse error and go to IDLE.
- WAIT_REL:
  - When synced clock=1 and synced data=1, pulse done and go to IDLE.
- Timeout:
  - In START, DATA, PARITY, ACK or WAIT_REL, if the timeout counter reaches TIMEOUT_CYCLES, both oe go to 0, error pulses and the state goes to IDLE.
  - Timeout takes priority over a fall in the same cycle.
- done and error are mutually exclusive and last exactly one cycle.
- cmd_ready returns to 1 in the cycle after done or error.
- rx_inhibit = (state != IDLE).
- The bit counter is 3 bits.
- An ignored fall (e.g. a glitch in INHIBIT or REQ) has no effect.
- A rising edge is never acted on.

Test Plan:
- Send 0xED with a device BFM (clock period 40 cycles, ACK=0, INHIBIT_CYCLES=20):
  - clk_oe is high for exactly 20 cycles, then REQ, then the clock is released.
  - Data bits seen at the BFM's rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; error stays 0.
- Send 0xF4:
  - Parity bit sampled by the BFM is 0.
  - Stop bit is 1, ACK is taken, done pulses.
- Send 0xFF with the BFM holding data high at the ACK clock:
  - error pulses one cycle; done stays 0.
  - The next cycle has cmd_ready=1 and both oe=0.
- Send with the BFM never clocking (TIMEOUT_CYCLES=500):
  - error pulses exactly 500 cycles after entering START.
  - Both lines are released.
- Raise cmd_valid with 0x00 mid-transfer of 0xED:
  - Ignored; the BFM receives only 0xED.
  - After done, a 0x00 command is accepted and sent with parity 1.
- Assert reset during DATA bit 4:
  - At the next edge both oe=0, cmd_ready=1, no done or error pulse.
  - A new send of 0xF4 completes normally.
